// File: rtl/preset_loader.sv
// preset_loader: packs the preset byte stream into BLOCK_LEN-cell RAM words and
// zero-fills the rest of the board.  rev 1.0
`default_nettype none

module preset_loader #(
  parameter int P_PARAM_N = 800,
  parameter int P_PARAM_M = 600,
  parameter int BLOCK_LEN = 32,
  parameter int ADDR_W    = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [BLOCK_LEN-1:0] wr_data,
  output logic                 busy,
  output logic                 finish
);

  localparam int WORDS = P_PARAM_N * P_PARAM_M / BLOCK_LEN;
  localparam int BPW   = BLOCK_LEN / 8;
  localparam int BI_W  = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [BI_W-1:0]   LAST_IDX  = BI_W'(BPW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state_q,     state_d;
  logic [ADDR_W-1:0]    word_addr_q, word_addr_d;
  logic [BI_W-1:0]      byte_idx_q,  byte_idx_d;
  logic [BLOCK_LEN-1:0] buf_q,       buf_d;
  logic                 wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q,   wr_addr_d;
  logic [BLOCK_LEN-1:0] wr_data_q,   wr_data_d;
  logic                 finish_q,    finish_d;
  logic [BLOCK_LEN-1:0] merged;

  always_comb begin
    merged = buf_q;
    for (int b = 0; b < BPW; b++) begin
      if (byte_idx_q == BI_W'(b)) merged[8*b +: 8] = in_byte;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    finish_d    = finish_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          word_addr_d = '0;
          byte_idx_d  = '0;
          buf_d       = '0;
          finish_d    = 1'b0;
        end else begin
          // DONE is entered with the final write; finish follows one cycle later.
          finish_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (byte_idx_q == LAST_IDX) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_addr_q;
            wr_data_d  = merged;
            buf_d      = '0;
            byte_idx_d = '0;
            if (word_addr_q == LAST_ADDR) begin
              state_d = S_DONE;
            end else begin
              word_addr_d = word_addr_q + 1'b1;
              if (in_last) state_d = S_FILL;
            end
          end else begin
            buf_d      = merged;
            byte_idx_d = byte_idx_q + 1'b1;
            if (in_last) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH, S_FILL: begin
        // The buffer is cleared after every word, so unfilled bytes are already zero.
        wr_en_d   = 1'b1;
        wr_addr_d = word_addr_q;
        wr_data_d = (state_q == S_FLUSH) ? buf_q : '0;
        buf_d     = '0;
        if (word_addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          word_addr_d = word_addr_q + 1'b1;
          state_d     = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      word_addr_q <= '0;
      byte_idx_q  <= '0;
      buf_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      finish_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      finish_q    <= finish_d;
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign finish   = finish_q;
  assign busy     = ~finish_q;

endmodule

`default_nettype wire

// File: tb/tb_preset_loader.sv
// tb_preset_loader: scoreboard bench for preset_loader on an 800x4 board (100 words).
`default_nettype none

module tb_preset_loader;

  localparam int N      = 800;
  localparam int M      = 4;
  localparam int BL     = 32;
  localparam int AW     = 24;
  localparam int WORDS  = N * M / BL;
  localparam int BPW    = BL / 8;
  localparam int NBYTES = WORDS * BPW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [BL-1:0] wr_data;
  logic          busy;
  logic          finish;

  int checks = 0;
  int errors = 0;
  int nwr    = 0;
  logic [AW+BL-1:0] sb[$];

  preset_loader #(
    .P_PARAM_N(N), .P_PARAM_M(M), .BLOCK_LEN(BL), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int addr, input logic [BL-1:0] data);
    sb.push_back({AW'(addr), data});
  endtask

  // Advance to the next falling edge and score any write the DUT presents.
  task automatic cyc();
    logic [AW+BL-1:0] exp;
    @(negedge clk);
    if (wr_en === 1'b1) begin
      nwr++;
      if (sb.size() == 0) begin
        check("unexpected_write", 64'({wr_addr, wr_data}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp = sb.pop_front();
        check("write", 64'({wr_addr, wr_data}), 64'(exp));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  function automatic logic [BL-1:0] word_of(input int i);
    logic [BL-1:0] w;
    for (int k = 0; k < BPW; k++) w[8*k +: 8] = 8'(i - (BPW - 1) + k);
    return w;
  endfunction

  // Stream bytes i[7:0]; in_last on the final byte only when the whole board is sent.
  task automatic load_stream(input int nbytes, input bit stall);
    int g;
    for (int i = 0; i < nbytes; i++) begin
      if (stall) begin
        g = $urandom_range(0, 7);
        repeat (g) cyc();
        if (i == 150) pulse_start();
      end
      if (i % BPW == BPW - 1) push(i / BPW, word_of(i));
      send_byte(8'(i), (i == NBYTES - 1));
    end
  endtask

  task automatic wait_finish(input string tag);
    logic prev_wr;
    bit   done;
    done    = 1'b0;
    prev_wr = wr_en;
    for (int k = 0; k < 2 * WORDS + 20; k++) begin
      cyc();
      if (finish === 1'b1) begin
        done = 1'b1;
        break;
      end
      prev_wr = wr_en;
    end
    check({tag, "_finish_reached"}, 64'(done), 64'd1);
    check({tag, "_finish_after_last_write"}, 64'(prev_wr), 64'd1);
    check({tag, "_wr_en_low"}, 64'(wr_en), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_write_count"}, 64'(nwr), 64'(WORDS));
    nwr = 0;
  endtask

  task automatic check_started(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_finish"}, 64'(finish), 64'd0);
  endtask

  initial begin
    repeat (3) cyc();
    check("rst_finish", 64'(finish), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    reset_n = 1'b1;
    cyc();

    // Full load without gaps.
    pulse_start();
    check_started("full");
    load_stream(NBYTES, 1'b0);
    wait_finish("full");

    // Overrun in DONE: bytes must be refused and nothing written.
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    repeat (8) begin
      cyc();
      check("overrun_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    cyc();
    check("overrun_no_writes", 64'(nwr), 64'd0);

    // Early end after 5 bytes, with an ignored start during FILL.
    pulse_start();
    check_started("early");
    push(0, 32'hFFFF_FFFF);
    push(1, 32'h0000_00FF);
    for (int a = 2; a < WORDS; a++) push(a, '0);
    repeat (4) send_byte(8'hFF, 1'b0);
    send_byte(8'hFF, 1'b1);
    repeat (3) cyc();
    pulse_start();
    wait_finish("early");

    // Full load with random gaps and an ignored start during LOAD.
    pulse_start();
    check_started("stall");
    load_stream(NBYTES, 1'b1);
    wait_finish("stall");

    // Reset in the middle of a load, then reload from address 0.
    pulse_start();
    load_stream(200, 1'b0);
    reset_n = 1'b0;
    cyc();
    check("midrst_finish", 64'(finish), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_wr_en", 64'(wr_en), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_sb_drained", 64'(sb.size()), 64'd0);
    reset_n = 1'b1;
    nwr = 0;
    cyc();
    pulse_start();
    check_started("reload");
    load_stream(NBYTES, 1'b0);
    wait_finish("reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
